// File: rtl/alu_datapath.sv
// alu_datapath: A/Q/M register datapath for add, subtract, Booth multiply and divide steps.
// Optional sticky signed-overflow flag on port ovf when ALU_DATAPATH_OVF_EN is defined.
module alu_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      c,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             out_valid,
  output logic             q_minus_one,
  output logic             q_zero,
  output logic             a_seven,
`ifdef ALU_DATAPATH_OVF_EN
  output logic             ovf,
`endif
  output logic             cnt_7
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic             qm1_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] m_n;
  logic [WIDTH-1:0] a_1;
  logic [WIDTH-1:0] q_1;
  logic             qm1_1;
  logic             lsh;
  logic             do_add;
  logic             do_sub;
  logic [WIDTH-1:0] a_2;
  logic [WIDTH-1:0] q_2;
  logic [WIDTH-1:0] m_op;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] a_3;
  logic [WIDTH-1:0] q_3;
  logic             ov_step;
  logic [WIDTH-1:0] a_4;
  logic [WIDTH-1:0] q_4;
  logic             qm1_4;
  logic [WIDTH-1:0] q_5;
  logic [CNT_W-1:0] cnt_n;
  logic [WIDTH-1:0] out_n;
  logic             out_we;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Loads/clears first; a division left shift feeds the trial add/sub so the
  // quotient bit reflects its sign; Booth right shift follows the add/sub.
  always_comb begin
    m_n   = c[0] ? inbus : m_q;
    a_1   = (c[0] | c[8]) ? '0 : a_q;
    q_1   = c[1] ? inbus : q_q;
    qm1_1 = (c[1] | c[8]) ? 1'b0 : qm1_q;

    lsh = c[4] & ~c[9];
    a_2 = lsh ? {a_1[WIDTH-2:0], q_1[WIDTH-1]} : a_1;
    q_2 = lsh ? {q_1[WIDTH-2:0], 1'b0} : q_1;

    do_sub  = c[3];
    do_add  = c[2] & ~c[3];
    m_op    = do_sub ? ~m_n : m_n;
    sum     = a_2 + m_op + WIDTH'(do_sub);
    a_3     = (do_add | do_sub) ? sum : a_2;
    ov_step = (do_add | do_sub)
            & (a_2[WIDTH-1] == m_op[WIDTH-1])
            & (sum[WIDTH-1] != a_2[WIDTH-1]);

    q_3 = lsh ? {q_2[WIDTH-1:1], ~a_3[WIDTH-1]} : q_2;

    a_4   = a_3;
    q_4   = q_3;
    qm1_4 = qm1_1;
    if (c[9]) begin
      a_4   = {a_3[WIDTH-1], a_3[WIDTH-1:1]};
      q_4   = {a_3[0], q_3[WIDTH-1:1]};
      qm1_4 = q_3[0];
    end

    q_5 = c[10] ? a_4 : q_4;

    cnt_n = cnt_q;
    if (c[1] | c[8]) begin
      cnt_n = '0;
    end else if (c[5]) begin
      cnt_n = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    out_we = c[6] | c[7];
    out_n  = c[7] ? q_5 : a_4;
  end

  // Datapath registers and the registered output word
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      outbus    <= '0;
      out_valid <= 1'b0;
    end else begin
      a_q       <= a_4;
      q_q       <= q_5;
      m_q       <= m_n;
      qm1_q     <= qm1_4;
      cnt_q     <= cnt_n;
      out_valid <= out_we;
      if (out_we) begin
        outbus <= out_n;
      end
    end
  end

`ifdef ALU_DATAPATH_OVF_EN
  // Sticky signed overflow, cleared along with A
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ((c[0] | c[8]) ? 1'b0 : ovf) | ov_step;
    end
  end
`else
  logic unused_ov;
  assign unused_ov = ov_step;
`endif

  assign q_minus_one = qm1_q;
  assign q_zero      = q_q[0];
  assign a_seven     = a_q[WIDTH-1];
  assign cnt_7       = (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: vector table, hand sequences for multiply/divide/priority,
// then random control words checked against an arithmetic reference model.
module tb_alu_datapath;

  logic        clk;
  logic        rst;
  logic [10:0] c;
  logic [7:0]  inbus;
  logic [7:0]  outbus;
  logic        out_valid;
  logic        q_minus_one;
  logic        q_zero;
  logic        a_seven;
  logic        cnt_7;
`ifdef ALU_DATAPATH_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  alu_datapath #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .c(c),
    .inbus(inbus),
    .outbus(outbus),
    .out_valid(out_valid),
    .q_minus_one(q_minus_one),
    .q_zero(q_zero),
    .a_seven(a_seven),
`ifdef ALU_DATAPATH_OVF_EN
    .ovf(ovf),
`endif
    .cnt_7(cnt_7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] ma, mq, mm, mout;
  logic       mqm1, mvalid, movf;
  int         mcnt;

  task automatic mdl_reset();
    ma = 0; mq = 0; mm = 0; mout = 0;
    mqm1 = 0; mvalid = 0; movf = 0; mcnt = 0;
  endtask

  task automatic mdl(input logic [10:0] cv, input logic [7:0] iv);
    logic [15:0] aq;
    logic [16:0] aqx;
    int r;
    if (cv[0]) begin mm = iv; ma = 0; movf = 0; end
    if (cv[1]) begin mq = iv; mqm1 = 0; mcnt = 0; end
    if (cv[8]) begin ma = 0; mqm1 = 0; mcnt = 0; movf = 0; end
    if (cv[4] && !cv[9]) begin
      aq = {ma, mq} << 1;
      ma = aq[15:8];
      mq = aq[7:0];
    end
    if (cv[2] || cv[3]) begin
      if (cv[3]) r = int'($signed(ma)) - int'($signed(mm));
      else       r = int'($signed(ma)) + int'($signed(mm));
      if (r > 127 || r < -128) movf = 1;
      ma = r[7:0];
    end
    if (cv[4] && !cv[9]) mq[0] = ~ma[7];
    if (cv[9]) begin
      aqx = 17'($signed({ma, mq, mqm1}) >>> 1);
      ma = aqx[16:9];
      mq = aqx[8:1];
      mqm1 = aqx[0];
    end
    if (cv[5] && !cv[1] && !cv[8]) mcnt = (mcnt + 1) % 8;
    if (cv[10]) mq = ma;
    mvalid = cv[6] | cv[7];
    if (cv[7]) mout = mq;
    else if (cv[6]) mout = ma;
  endtask

  function automatic logic [12:0] obs();
    return {outbus, out_valid, q_minus_one, q_zero, a_seven, cnt_7};
  endfunction

  function automatic logic [12:0] mexp();
    return {mout, mvalid, mqm1, mq[0], ma[7], (mcnt == 7)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [10:0] cv, input logic [7:0] iv);
    rst = r; c = cv; inbus = iv;
    @(posedge clk);
    #1;
    if (r) mdl_reset();
    else mdl(cv, iv);
  endtask

  typedef struct {
    string       nm;
    logic        r;
    logic [10:0] cv;
    logic [7:0]  iv;
    int          rep;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // exp = {outbus, out_valid, q_minus_one, q_zero, a_seven, cnt_7}
    tbl[0]  = '{"reset",    1'b1, 11'h7FF, 8'hFF, 1, {8'h00, 5'b00000}};
    tbl[1]  = '{"idle",     1'b0, 11'h000, 8'h5A, 5, {8'h00, 5'b00000}};
    tbl[2]  = '{"add_ldm",  1'b0, 11'h001, 8'h25, 1, {8'h00, 5'b00000}};
    tbl[3]  = '{"add_ldq",  1'b0, 11'h002, 8'h1A, 1, {8'h00, 5'b00000}};
    tbl[4]  = '{"add_shl",  1'b0, 11'h010, 8'h00, 8, {8'h00, 5'b00100}};
    tbl[5]  = '{"add_op",   1'b0, 11'h004, 8'h00, 1, {8'h00, 5'b00100}};
    tbl[6]  = '{"add_xfer", 1'b0, 11'h400, 8'h00, 1, {8'h00, 5'b00100}};
    tbl[7]  = '{"add_out",  1'b0, 11'h080, 8'h00, 1, {8'h3F, 5'b10100}};
    tbl[8]  = '{"add_idle", 1'b0, 11'h000, 8'h00, 1, {8'h3F, 5'b00100}};
    tbl[9]  = '{"sub_ldm",  1'b0, 11'h001, 8'h05, 1, {8'h3F, 5'b00100}};
    tbl[10] = '{"sub_ldq",  1'b0, 11'h002, 8'h03, 1, {8'h3F, 5'b00100}};
    tbl[11] = '{"sub_shl",  1'b0, 11'h010, 8'h00, 8, {8'h3F, 5'b00100}};
    tbl[12] = '{"sub_op",   1'b0, 11'h008, 8'h00, 1, {8'h3F, 5'b00110}};
    tbl[13] = '{"sub_xfer", 1'b0, 11'h400, 8'h00, 1, {8'h3F, 5'b00010}};
    tbl[14] = '{"sub_out",  1'b0, 11'h080, 8'h00, 1, {8'hFE, 5'b10010}};
    tbl[15] = '{"sub_idle", 1'b0, 11'h000, 8'h00, 1, {8'hFE, 5'b00010}};

    rst = 1'b0; c = '0; inbus = '0;
    mdl_reset();
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < tbl[i].rep; k++) step(tbl[i].r, tbl[i].cv, tbl[i].iv);
      chk(tbl[i].nm, 32'(obs()), 32'(tbl[i].exp));
    end

    // Booth multiply 7 x (-3)
    step(0, 11'h001, 8'h07);
    step(0, 11'h002, 8'hFD);
    step(0, 11'h100, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (q_zero && !q_minus_one) step(0, 11'h008, 8'h00);
      else if (!q_zero && q_minus_one) step(0, 11'h004, 8'h00);
      step(0, 11'h220, 8'h00);
      chk("booth_cnt7", 32'(cnt_7), 32'(i == 6));
    end
    step(0, 11'h040, 8'h00);
    chk("booth_hi", 32'({out_valid, outbus}), 32'h1FF);
    step(0, 11'h080, 8'h00);
    chk("booth_lo", 32'({out_valid, outbus}), 32'h1EB);

    // restoring divide 23 / 4
    step(0, 11'h001, 8'h04);
    step(0, 11'h002, 8'h17);
    for (int i = 0; i < 8; i++) begin
      step(0, 11'h018, 8'h00);
      if (a_seven) step(0, 11'h004, 8'h00);
      step(0, 11'h020, 8'h00);
    end
    step(0, 11'h080, 8'h00);
    chk("div_quot", 32'(outbus), 32'h05);
    step(0, 11'h040, 8'h00);
    chk("div_rem", 32'(outbus), 32'h03);
    step(0, 11'h0C0, 8'h00);
    chk("out_both_q", 32'(outbus), 32'h05);

    // add and subtract together: subtract wins
    step(0, 11'h001, 8'h03);
    step(0, 11'h00C, 8'h00);
    step(0, 11'h040, 8'h00);
    chk("addsub_sub", 32'({a_seven, outbus}), 32'h1FD);

    // increment with clear: clear wins
    step(0, 11'h002, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 11'h020, 8'h00);
    step(0, 11'h120, 8'h00);
    for (int i = 0; i < 6; i++) step(0, 11'h020, 8'h00);
    chk("cnt_clr_6", 32'(cnt_7), 32'h0);
    step(0, 11'h020, 8'h00);
    chk("cnt_clr_7", 32'(cnt_7), 32'h1);

`ifdef ALU_DATAPATH_OVF_EN
    step(0, 11'h001, 8'h01);
    step(0, 11'h002, 8'h7F);
    for (int i = 0; i < 8; i++) step(0, 11'h010, 8'h00);
    step(0, 11'h004, 8'h00);
    chk("ovf_set", 32'(ovf), 32'h1);
    step(0, 11'h000, 8'h00);
    chk("ovf_sticky", 32'(ovf), 32'h1);
    step(0, 11'h100, 8'h00);
    chk("ovf_clr", 32'(ovf), 32'h0);
`endif

    // random control words against the model
    step(1, 11'h000, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      logic        r;
      logic [10:0] cv;
      r  = ($urandom_range(0, 99) == 0);
      cv = 11'($urandom & $urandom);
      step(r, cv, 8'($urandom));
      chk("random", 32'(obs()), 32'(mexp()));
`ifdef ALU_DATAPATH_OVF_EN
      chk("random_ovf", 32'(ovf), 32'(movf));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
